// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : receiver state encoding and baud constants shared by the UART.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int CLKS_PER_BIT_115200 = 868;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// uart_rx_core : 8N1 deserialiser with 2-flop synchroniser and mid-bit sampling.
// Revision     : 1.0
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int             c_bw   = $clog2(CLKS_PER_BIT);
    localparam logic [c_bw-1:0] c_full = c_bw'(CLKS_PER_BIT - 1);
    localparam logic [c_bw-1:0] c_half = c_bw'(CLKS_PER_BIT / 2 - 1);

    logic            r_rx_m;
    logic            r_rx_s;
    rx_state_t       r_state;
    rx_state_t       w_state;
    logic [c_bw-1:0] r_cnt;
    logic [c_bw-1:0] w_cnt;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift;
    logic            w_tick;
    logic            w_frame_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_m    <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            frame_err <= 1'b0;
        end else begin
            r_rx_m    <= rx;
            r_rx_s    <= r_rx_m;
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_shift   <= w_shift;
            frame_err <= w_frame_err;
        end
    end

    assign w_tick  = (r_cnt == '0) && (r_state != ST_IDLE);
    assign rx_byte = r_shift;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_idx       = r_idx;
        w_shift     = r_shift;
        byte_valid  = 1'b0;
        w_frame_err = 1'b0;
        if ((r_state != ST_IDLE) && !w_tick) begin
            w_cnt = r_cnt - 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_cnt   = c_half;
                    w_state = ST_START;
                end
            end
            ST_START: begin
                // A start bit that is gone by its midpoint was a glitch.
                if (w_tick) begin
                    if (!r_rx_s) begin
                        w_cnt   = c_full;
                        w_idx   = '0;
                        w_state = ST_DATA;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift[r_idx] = r_rx_s;
                    w_cnt          = c_full;
                    if (r_idx == 3'd7) begin
                        w_state = ST_STOP;
                    end else begin
                        w_idx = r_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        byte_valid = 1'b1;
                        w_state    = ST_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (r_rx_s) begin
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/uart_fifoed_recv.sv
`default_nettype none
// ============================================================================
// uart_fifoed_recv : UART 8N1 receiver feeding a show-ahead byte FIFO.
// Revision         : 1.0
// ============================================================================
module uart_fifoed_recv
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int FIFO_AW      = 4,
    parameter int AFULL_LEVEL  = 12
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       RX,
    input  logic       rd_en,
    output logic [7:0] dat,
    output logic       fifo_empty,
    output logic       fifo_afull,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun
);

    localparam int                 c_depth = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   c_full  = (FIFO_AW + 1)'(c_depth);
    localparam logic [FIFO_AW:0]   c_afull = (FIFO_AW + 1)'(AFULL_LEVEL);

    logic [7:0]         w_rx_byte;
    logic               w_byte_valid;
    logic [7:0]         r_mem [c_depth];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_pop;
    logic               w_push;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk        (clk_100MHz),
        .reset_n    (reset_n),
        .rx         (RX),
        .rx_byte    (w_rx_byte),
        .byte_valid (w_byte_valid),
        .frame_err  (frame_err)
    );

    assign fifo_empty = (r_count == '0);
    assign fifo_full  = (r_count == c_full);
    assign fifo_afull = (r_count >= c_afull);
    assign dat        = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_pop  = rd_en && !fifo_empty;
    assign w_push = w_byte_valid && (!fifo_full || w_pop);

    always_ff @(posedge clk_100MHz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rx_byte;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= w_byte_valid && fifo_full && !w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifoed_recv.sv
`default_nettype none
// ============================================================================
// tb_uart_fifoed_recv : scoreboard bench with a queue-based FIFO model.
// Revision            : 1.0
// ============================================================================
module tb_uart_fifoed_recv;

    localparam int CPB   = 16;
    localparam int AW    = 4;
    localparam int AFL   = 12;
    localparam int DEPTH = 16;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx      = 1'b1;
    logic       rd_en   = 1'b0;
    logic [7:0] dat;
    logic       fifo_empty;
    logic       fifo_afull;
    logic       fifo_full;
    logic       frame_err;
    logic       overrun;

    uart_fifoed_recv #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW),
        .AFULL_LEVEL  (AFL)
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .RX         (rx),
        .rd_en      (rd_en),
        .dat        (dat),
        .fifo_empty (fifo_empty),
        .fifo_afull (fifo_afull),
        .fifo_full  (fifo_full),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mdl[$];     // bytes the FIFO should hold, head first
    logic [1:0] exp_ev[$];  // expected error pulses: {overrun, frame_err}

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    // Monitor: checks every accepted pop and every error pulse.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_en && !fifo_empty) begin
                if (mdl.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_model_empty: dat=%h popped, model holds nothing", dat);
                end else begin
                    cmp("pop_dat", dat, mdl.pop_front());
                end
            end
            if (frame_err || overrun) begin
                if (exp_ev.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: {overrun,frame_err}=%b, none expected", {overrun, frame_err});
                end else begin
                    cmp("err_pulse", {overrun, frame_err}, exp_ev.pop_front());
                end
            end
        end
    end

    // Called one step after a rising edge; leaves the line idle afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Model decides the outcome up front; optionally pops on the push tick
    // (start edge + 9.5 bit times + 3 synchroniser/FSM cycles).
    task automatic frame(input logic [7:0] b, input logic stop_ok, input logic pop_on_tick);
        if (!stop_ok) begin
            exp_ev.push_back(2'b01);
        end else if (mdl.size() >= DEPTH && !pop_on_tick) begin
            exp_ev.push_back(2'b10);
        end else begin
            mdl.push_back(b);
        end
        if (pop_on_tick) begin
            fork
                send_frame(b, stop_ok);
                begin
                    repeat (CPB * 19 / 2 + 2) @(posedge clk);
                    #1 rd_en = 1'b1;
                    @(posedge clk);
                    #1 rd_en = 1'b0;
                end
            join
        end else begin
            send_frame(b, stop_ok);
        end
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_flags(input string name);
        cmp({name, "_empty"}, fifo_empty, mdl.size() == 0);
        cmp({name, "_afull"}, fifo_afull, mdl.size() >= AFL);
        cmp({name, "_full"},  fifo_full,  mdl.size() == DEPTH);
        if (mdl.size() != 0) begin
            cmp({name, "_head"}, dat, mdl[0]);
        end
    endtask

    initial begin
        repeat (80000) @(posedge clk);
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: cycle budget expired");
        summary();
        $finish;
    end

    initial begin
        logic [7:0] b;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_flags("reset");
        cmp("reset_frame_err", frame_err, 1'b0);
        cmp("reset_overrun", overrun, 1'b0);

        frame(8'hA5, 1'b1, 1'b0);
        check_flags("t1_a5");
        pop_n(1);
        check_flags("t1_drained");

        rx = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_flags("t2_glitch");

        frame(8'h3C, 1'b0, 1'b0);
        check_flags("t3_bad_stop");
        frame(8'h55, 1'b1, 1'b0);
        check_flags("t3_55");
        pop_n(1);

        for (int i = 0; i < DEPTH; i++) begin
            frame(8'(i), 1'b1, 1'b0);
            check_flags($sformatf("t4_fill%0d", i));
        end
        frame(8'hFF, 1'b1, 1'b0);
        check_flags("t4_overrun");

        frame(8'h77, 1'b1, 1'b1);
        check_flags("t5_pop_on_tick");
        pop_n(DEPTH);
        check_flags("t5_drained");

        // Reset lands inside data bit 6 of 0xC3, a '1' bit, so no false start follows.
        fork
            send_frame(8'hC3, 1'b1);
            begin
                repeat (CPB * 7 + CPB / 2 - 1) @(posedge clk);
                #1 reset_n = 1'b0;
                @(posedge clk);
                #1 reset_n = 1'b1;
            end
        join
        check_flags("t6_after_reset");
        frame(8'h81, 1'b1, 1'b0);
        check_flags("t6_81");
        pop_n(1);

        repeat (40) begin
            b = 8'($urandom);
            frame(b, ($urandom_range(0, 7) != 0), 1'b0);
            check_flags("rand");
            pop_n($urandom_range(0, 1));
        end
        pop_n(mdl.size() + 1);
        check_flags("final");
        cmp("pending_pulses", exp_ev.size(), 0);

        summary();
        $finish;
    end

endmodule
`default_nettype wire
